lcd_hd44780_ctrl: RTL

//  Parametrised HD44780 character-LCD controller; successor to the fixed 2x16 driver.

---
 rtl/lcd_hd44780_ctrl_if.sv | 25 ++
 rtl/lcd_hd44780_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_ctrl_if.sv
// Host-side bundle of the HD44780 controller: character buffer, refresh handshake and LCD pins.
// The controller takes the slave view; the character source/host takes the master view.
interface lcd_hd44780_ctrl_if #(
    parameter int ROWS = 2,
    parameter int COLS = 16
);
    logic [ROWS*COLS*8-1:0] chars;
    logic                   refresh_req;
    logic                   refresh_ack;
    logic                   busy;
    logic                   LCD_EN;
    logic                   LCD_RS;
    logic                   LCD_RW;
    logic [7:0]             LCD_DATA;

    modport master (
        output chars, refresh_req,
        input  refresh_ack, busy, LCD_EN, LCD_RS, LCD_RW, LCD_DATA
    );

    modport slave (
        input  chars, refresh_req,
        output refresh_ack, busy, LCD_EN, LCD_RS, LCD_RW, LCD_DATA
    );
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// Parametrised HD44780 character-LCD controller (1/2/4 rows, 8-40 cols, 8- or 4-bit bus).
// Single-clock design: every LCD bus phase lasts one tick of a CLOCK_50 divider.
module lcd_hd44780_ctrl #(
    parameter int ROWS       = 2,
    parameter int COLS       = 16,
    parameter int BUS4       = 0,
    parameter int CONTINUOUS = 1,
    parameter int TICK_DIV   = 125000,
    parameter int LONG_TICKS = 1
) (
    input logic               CLOCK_50,
    input logic               Reset_n,
    lcd_hd44780_ctrl_if.slave bus
);
    localparam int              NB        = ROWS * COLS;
    localparam int              IW        = (NB > 1) ? $clog2(NB) : 1;
    localparam int              TW        = $clog2(TICK_DIV + 1);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [1:0]      ROW_LAST  = 2'(ROWS - 1);
    localparam logic [5:0]      COL_LAST  = 6'(COLS);
    localparam logic [3:0]      INIT_LAST = (BUS4 != 0) ? 4'd8 : 4'd7;
    localparam logic [15:0]     LONG_N    = 16'(LONG_TICKS);
    localparam logic [7:0]      FS        = 8'h20 | ((BUS4 != 0) ? 8'h00 : 8'h10)
                                                  | ((ROWS == 1) ? 8'h00 : 8'h08);

    typedef enum logic [1:0] {S_INIT0, S_INIT, S_IDLE, S_REFRESH} state_e;
    typedef enum logic [2:0] {PH_HI_EN, PH_HI_HOLD, PH_LO_EN, PH_LO_HOLD, PH_WAIT} phase_e;

    logic [TW-1:0] tcnt_q;
    logic          tick;

    state_e        state_q;
    phase_e        phase_q;
    logic [3:0]    idx_q;
    logic [1:0]    row_q;
    logic [5:0]    col_q;
    logic [15:0]   wait_q;
    logic          pend_q;
    logic          served_q;
    logic          ack_q;
    logic          busy_q;
    logic          en_q;
    logic          rs_q;
    logic [7:0]    data_q;
    logic [7:0]    snap_q [NB];

    logic [7:0]    cur_byte;
    logic          cur_rs;
    logic          nib_only;
    logic          long_cmd;
    logic          in_xfer;
    logic          bus_last;
    logic          item_done;
    logic          init_done;
    logic          pass_done;
    logic          start_pass;
    logic [IW-1:0] sidx;

    function automatic logic [7:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h14;
            default: return 8'h54;
        endcase
    endfunction

    assign tick = (tcnt_q == TICK_LAST);

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) tcnt_q <= '0;
        else          tcnt_q <= tick ? '0 : tcnt_q + 1'b1;
    end

    // col_q == 0 is the row address command; columns 1..COLS map to snapshot bytes.
    assign sidx = IW'(int'(row_q) * COLS + int'(col_q) - 1);

    always_comb begin
        cur_byte = 8'h00;
        cur_rs   = 1'b0;
        nib_only = 1'b0;
        if (state_q == S_REFRESH) begin
            if (col_q == '0) begin
                cur_byte = 8'h80 | row_base(row_q);
            end else begin
                cur_byte = snap_q[sidx];
                cur_rs   = 1'b1;
            end
        end else if (BUS4 != 0) begin
            case (idx_q)
                4'd0, 4'd1, 4'd2: begin cur_byte = 8'h30; nib_only = 1'b1; end
                4'd3:             begin cur_byte = 8'h20; nib_only = 1'b1; end
                4'd4:             cur_byte = FS;
                4'd5:             cur_byte = 8'h08;
                4'd6:             cur_byte = 8'h01;
                4'd7:             cur_byte = 8'h0C;
                default:          cur_byte = 8'h06;
            endcase
        end else begin
            case (idx_q)
                4'd0, 4'd1, 4'd2, 4'd3: cur_byte = FS;
                4'd4:                   cur_byte = 8'h08;
                4'd5:                   cur_byte = 8'h01;
                4'd6:                   cur_byte = 8'h0C;
                default:                cur_byte = 8'h06;
            endcase
        end
    end

    assign long_cmd   = !cur_rs && (cur_byte == 8'h01 || cur_byte == 8'h02) && (LONG_TICKS > 0);
    assign in_xfer    = (state_q == S_INIT) || (state_q == S_REFRESH);
    assign bus_last   = (BUS4 == 0 || nib_only) ? (phase_q == PH_HI_HOLD) : (phase_q == PH_LO_HOLD);
    assign item_done  = tick && in_xfer &&
                        ((bus_last && !long_cmd) || (phase_q == PH_WAIT && wait_q == 16'd1));
    assign init_done  = item_done && (state_q == S_INIT) && (idx_q == INIT_LAST);
    assign pass_done  = item_done && (state_q == S_REFRESH) && (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign start_pass = ((CONTINUOUS != 0) && (init_done || pass_done)) ||
                        (tick && (state_q == S_IDLE) && pend_q);

    // Later assignments deliberately override earlier ones: item advance beats the
    // phase step, and a new pass entry beats everything else.
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_INIT0;
            phase_q  <= PH_HI_EN;
            idx_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            wait_q   <= '0;
            pend_q   <= 1'b0;
            served_q <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b1;
            en_q     <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= '0;
            for (int unsigned i = 0; i < NB; i++) snap_q[i] <= '0;
        end else begin
            ack_q <= pass_done && served_q;
            if (bus.refresh_req) pend_q <= 1'b1;

            if (tick && state_q == S_INIT0) begin
                state_q <= S_INIT;
                idx_q   <= '0;
                phase_q <= PH_HI_EN;
            end

            if (tick && in_xfer) begin
                unique case (phase_q)
                    PH_HI_EN: begin
                        en_q    <= 1'b1;
                        rs_q    <= cur_rs;
                        data_q  <= (BUS4 != 0) ? {cur_byte[7:4], 4'h0} : cur_byte;
                        phase_q <= PH_HI_HOLD;
                    end
                    PH_HI_HOLD: begin
                        en_q    <= 1'b0;
                        phase_q <= PH_LO_EN;
                    end
                    PH_LO_EN: begin
                        en_q    <= 1'b1;
                        data_q  <= {cur_byte[3:0], 4'h0};
                        phase_q <= PH_LO_HOLD;
                    end
                    PH_LO_HOLD: en_q <= 1'b0;
                    default:    wait_q <= wait_q - 1'b1;
                endcase
                if (bus_last && long_cmd) begin
                    phase_q <= PH_WAIT;
                    wait_q  <= LONG_N;
                end
            end

            if (item_done) begin
                phase_q <= PH_HI_EN;
                if (state_q == S_INIT) begin
                    idx_q <= idx_q + 1'b1;
                    if (init_done) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end else if (pass_done) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end else if (col_q == COL_LAST) begin
                    row_q <= row_q + 1'b1;
                    col_q <= '0;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end

            if (start_pass) begin
                state_q  <= S_REFRESH;
                busy_q   <= 1'b1;
                phase_q  <= PH_HI_EN;
                row_q    <= '0;
                col_q    <= '0;
                pend_q   <= 1'b0;
                served_q <= pend_q;
                for (int unsigned i = 0; i < NB; i++) snap_q[i] <= bus.chars[i*8 +: 8];
            end
        end
    end

    assign bus.LCD_EN      = en_q;
    assign bus.LCD_RS      = rs_q;
    assign bus.LCD_RW      = 1'b0;
    assign bus.LCD_DATA    = data_q;
    assign bus.refresh_ack = ack_q;
    assign bus.busy        = busy_q;
endmodule
